// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM shared memory-port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    // Returned on a forced (timed-out) completion so a hung fetch executes as a no-op.
    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single shared instruction/data memory port of the 5-stage pipeline.
//
// Handshake: a requester raises x_req with stable address/data and holds it until it
// sees x_ack (a registered, one-cycle pulse). Requests are only sampled in IDLE, so a
// requester that has nothing further to issue must drop x_req in the cycle x_ack is
// high; a request still high in that cycle is taken as a new access. On the memory
// side, mem_re/mem_we stay high for the whole busy state and mem_ready=1 completes the
// access at that edge, with mem_rdata valid in the same cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_DBURST = 4,
    parameter int TIMEOUT    = 16,
    localparam int SC_W      = $clog2(MAX_DBURST + 1),
    localparam int BC_W      = $clog2(TIMEOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              iord,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              timeout_err,
    output logic [1:0]        dbg_state,
    output logic [SC_W-1:0]   dbg_starve_cnt
);

    arb_state_e        state_q, state_d;
    logic              iord_q, iord_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [BC_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              starve_ok;
    logic              timed_out;
    logic [DATA_W-1:0] cpl_data;

    // Data may still win a conflict only while the fetch has not been passed over too often.
    assign starve_ok = (starve_cnt_q < SC_W'(MAX_DBURST));
    assign timed_out = (busy_cnt_q == BC_W'(TIMEOUT - 1));

    // Grant decision, access sequencing, counters and completion data.
    always_comb begin
        state_d       = state_q;
        iord_d        = iord_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_re_d      = mem_re_q;
        mem_we_d      = mem_we_q;
        if_ack_d      = 1'b0;
        d_ack_d       = 1'b0;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        starve_cnt_d  = starve_cnt_q;
        busy_cnt_d    = busy_cnt_q;
        timeout_err_d = timeout_err_q;
        cpl_data      = mem_ready ? mem_rdata : DATA_W'(NOP);

        unique case (state_q)
            IDLE: begin
                if (d_req && (!if_req || starve_ok)) begin
                    state_d     = BUSY_D;
                    iord_d      = 1'b1;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_re_d    = ~d_we;
                    mem_we_d    = d_we;
                    busy_cnt_d  = '0;
                    if (!if_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != SC_W'(MAX_DBURST)) begin
                        starve_cnt_d = starve_cnt_q + SC_W'(1);
                    end
                end else if (if_req) begin
                    state_d      = BUSY_I;
                    iord_d       = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_re_d     = 1'b1;
                    mem_we_d     = 1'b0;
                    busy_cnt_d   = '0;
                    starve_cnt_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready || timed_out) begin
                    // A ready arriving on the timeout cycle is a normal completion.
                    state_d  = IDLE;
                    iord_d   = 1'b0;
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!mem_ready) begin
                        timeout_err_d = 1'b1;
                    end
                    if (state_q == BUSY_I) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = cpl_data;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = cpl_data;
                        end
                    end
                end else begin
                    busy_cnt_d = busy_cnt_q + BC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            iord_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            starve_cnt_q  <= '0;
            busy_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            iord_q        <= iord_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_re_q      <= mem_re_d;
            mem_we_q      <= mem_we_d;
            if_ack_q      <= if_ack_d;
            d_ack_q       <= d_ack_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            starve_cnt_q  <= starve_cnt_d;
            busy_cnt_q    <= busy_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign if_ack         = if_ack_q;
    assign if_rdata       = if_rdata_q;
    assign d_ack          = d_ack_q;
    assign d_rdata        = d_rdata_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_re         = mem_re_q;
    assign mem_we         = mem_we_q;
    assign iord           = iord_q;
    assign timeout_err    = timeout_err_q;
    assign stall_if       = if_req & ~if_ack_q;
    assign stall_mem      = d_req & ~d_ack_q;
    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt_q;

endmodule
